p405s_dcu_st_data_buf: RTL and testbench

P405S_DCU_ST_DATA_BUF -- requirements
Module: p405s_dcu_st_data_buf

---
 rtl/p405s_dcu_pkg.sv | 27 ++
 rtl/p405s_dcu_par_chk.sv | 30 +++
 rtl/p405s_dcu_st_data_buf.sv | 171 +++++++++++++++++
 tb/tb_p405s_dcu_st_data_buf.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/p405s_dcu_pkg.sv
// ---------------------------------------------------------------------------
// p405s_dcu_pkg
// Shared DCU definitions: store-buffer geometry, the store-buffer entry
// layout and the odd-parity byte function used wherever byte parity is
// generated or checked.
// ---------------------------------------------------------------------------
package p405s_dcu_pkg;

  localparam int DEPTH = 4;  // store data buffer entries
  localparam int PTR_W = 2;  // read/write pointer width (wraps modulo DEPTH)
  localparam int CNT_W = 3;  // occupancy count width (0..DEPTH)

  // One buffered store. Big-endian numbering: byte n is data[8n:8n+7],
  // covered by par[n] and enabled by be[n].
  typedef struct packed {
    logic [0:31] data;
    logic [0:3]  par;
    logic [0:3]  be;
    logic [0:29] addr;
  } st_entry_t;

  // Odd parity: the parity bit makes the total number of ones odd.
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/p405s_dcu_par_chk.sv
// ---------------------------------------------------------------------------
// p405s_dcu_par_chk
// Four-byte odd-parity checker. Flags each byte whose parity bit disagrees
// with the odd parity of its data, but only for bytes that are enabled.
//
// Ports
//   data_i [0:31]  word under check, byte n = data_i[8n:8n+7]
//   par_i  [0:3]   received parity, bit n covers byte n
//   be_i   [0:3]   byte enables, disabled bytes never report
//   mism_o [0:3]   per-byte mismatch vector
// ---------------------------------------------------------------------------
module p405s_dcu_par_chk
  import p405s_dcu_pkg::*;
(
  input  logic [0:31] data_i,
  input  logic [0:3]  par_i,
  input  logic [0:3]  be_i,
  output logic [0:3]  mism_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    mism_o = '0;
    for (int n = 0; n < 4; n++) begin
      mism_o[n] = be_i[n] & (par_i[n] ^ odd_par(data_i[8*n +: 8]));
    end
  end

endmodule

// File: rtl/p405s_dcu_st_data_buf.sv
// ---------------------------------------------------------------------------
// p405s_dcu_st_data_buf
// Four-entry store data buffer between the data-steering stage and the
// data-cache write port. Entries leave in FIFO order. A store to the same
// word address as the youngest entry is merged byte-wise into that entry
// when at least two entries are held (the head is never touched, since the
// write port may be consuming it). Byte parity is checked on every accepted
// enqueue and reported one cycle later; the data is stored as received.
//
// Ports
//   CB, reset                     clock, synchronous active-high reset
//   enq_valid/data/par/be/addr    incoming steered store
//   enq_ready                     buffer not full (a same-cycle pop does not
//                                 make room)
//   deq_valid/data/par/be/addr    head entry, combinational from storage
//   deq_ack                       write port consumes the head
//   flush                         discard all entries
//   par_err, par_err_byte         one-cycle enqueue parity error report
//   full, empty, count            occupancy status
// ---------------------------------------------------------------------------
module p405s_dcu_st_data_buf
  import p405s_dcu_pkg::*;
(
  input  logic        CB,
  input  logic        reset,
  input  logic        enq_valid,
  input  logic [0:31] enq_data,
  input  logic [0:3]  enq_par,
  input  logic [0:3]  enq_be,
  input  logic [0:29] enq_addr,
  output logic        enq_ready,
  output logic        deq_valid,
  output logic [0:31] deq_data,
  output logic [0:3]  deq_par,
  output logic [0:3]  deq_be,
  output logic [0:29] deq_addr,
  input  logic        deq_ack,
  input  logic        flush,
  output logic        par_err,
  output logic [0:3]  par_err_byte,
  output logic        full,
  output logic        empty,
  output logic [0:2]  count
);

  st_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             par_err_q, par_err_d;
  logic [0:3]       par_err_byte_q, par_err_byte_d;

  logic             accept;
  logic             merge;
  logic             push;
  logic             pop;
  logic [0:3]       mism;
  st_entry_t        head;
  st_entry_t        tail_merged;
  st_entry_t        enq_entry;

  // ---------------- status and head presentation ----------------
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign count     = count_q;

  assign head     = mem_q[rd_ptr_q];
  assign deq_data = head.data;
  assign deq_par  = head.par;
  assign deq_be   = head.be;
  assign deq_addr = head.addr;

  assign par_err      = par_err_q;
  assign par_err_byte = par_err_byte_q;

  // ---------------- handshake decode ----------------
  // The tail is the most recently written entry, one behind the write pointer.
  assign tail_ptr = wr_ptr_q - PTR_W'(1);
  assign accept   = enq_valid & enq_ready & ~flush;
  // With a single entry the tail is the head, so merging needs two or more.
  assign merge    = accept & (count_q >= CNT_W'(2))
                  & (enq_addr == mem_q[tail_ptr].addr);
  assign push     = accept & ~merge;
  assign pop      = deq_valid & deq_ack & ~flush;

  assign enq_entry = '{data: enq_data, par: enq_par, be: enq_be, addr: enq_addr};

  p405s_dcu_par_chk u_par_chk (
    .data_i (enq_data),
    .par_i  (enq_par),
    .be_i   (enq_be),
    .mism_o (mism)
  );

  // Tail entry after a byte-wise merge: enabled bytes take the new data and
  // parity, byte enables accumulate.
  always_comb begin
    tail_merged = mem_q[tail_ptr];
    for (int n = 0; n < 4; n++) begin
      if (enq_be[n]) begin
        tail_merged.data[8*n +: 8] = enq_data[8*n +: 8];
        tail_merged.par[n]         = enq_par[n];
      end
    end
    tail_merged.be = mem_q[tail_ptr].be | enq_be;
  end

  // ---------------- next-state ----------------
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    par_err_d      = 1'b0;
    par_err_byte_d = '0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Bytes with be clear never report, so the vector is zero with no error.
      if (accept) begin
        par_err_d      = |mism;
        par_err_byte_d = mism;
      end
    end
  end

  // ---------------- control state ----------------
  always_ff @(posedge CB) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      par_err_q      <= 1'b0;
      par_err_byte_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      par_err_q      <= par_err_d;
      par_err_byte_q <= par_err_byte_d;
    end
  end

  // ---------------- entry storage ----------------
  // NOTE: the entry array has no reset; the count and pointers alone decide
  // which entries are live, so stale contents are never observed as valid.
  always_ff @(posedge CB) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enq_entry;
    end else if (merge) begin
      mem_q[tail_ptr] <= tail_merged;
    end
  end

endmodule

// File: tb/tb_p405s_dcu_st_data_buf.sv
// ---------------------------------------------------------------------------
// tb_p405s_dcu_st_data_buf
// Directed scenarios followed by randomized traffic. The negedge monitor keeps
// the expected buffer contents as a queue of entries: it compares the DUT's
// status and head against the queue, pops on each dequeue handshake, and
// records what the coming clock edge will enqueue, merge, flush or reset.
// ---------------------------------------------------------------------------
module tb_p405s_dcu_st_data_buf;

  typedef struct {
    logic [0:31] data;
    logic [0:3]  par;
    logic [0:3]  be;
    logic [0:29] addr;
  } ent_t;

  logic        CB = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic [0:31] enq_data;
  logic [0:3]  enq_par;
  logic [0:3]  enq_be;
  logic [0:29] enq_addr;
  logic        enq_ready;
  logic        deq_valid;
  logic [0:31] deq_data;
  logic [0:3]  deq_par;
  logic [0:3]  deq_be;
  logic [0:29] deq_addr;
  logic        deq_ack;
  logic        flush;
  logic        par_err;
  logic [0:3]  par_err_byte;
  logic        full;
  logic        empty;
  logic [0:2]  count;

  int          total = 0;
  int          bad   = 0;
  logic        chk_en = 1'b0;

  ent_t        exp_q[$];
  logic [0:3]  exp_pe = '0;
  int          pre;
  ent_t        t;
  logic [0:3]  gp;

  p405s_dcu_st_data_buf dut (
    .CB           (CB),
    .reset        (reset),
    .enq_valid    (enq_valid),
    .enq_data     (enq_data),
    .enq_par      (enq_par),
    .enq_be       (enq_be),
    .enq_addr     (enq_addr),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_data     (deq_data),
    .deq_par      (deq_par),
    .deq_be       (deq_be),
    .deq_addr     (deq_addr),
    .deq_ack      (deq_ack),
    .flush        (flush),
    .par_err      (par_err),
    .par_err_byte (par_err_byte),
    .full         (full),
    .empty        (empty),
    .count        (count)
  );

  always #5 CB = ~CB;

  // Correct odd parity: the parity bit is 1 when the byte has an even number
  // of ones.
  function automatic logic [0:3] good_par(input logic [0:31] d);
    logic [0:3] r;
    for (int n = 0; n < 4; n++) r[n] = (($countones(d[8*n +: 8]) % 2) == 0);
    return r;
  endfunction

  function automatic logic [71:0] pack(input ent_t e);
    return {2'b00, e.data, e.par, e.be, e.addr};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CB) begin
    pre = exp_q.size();
    if (chk_en) begin
      check("deq_valid",    72'(deq_valid),    72'(pre != 0));
      check("count",        72'(count),        72'(pre));
      check("full",         72'(full),         72'(pre == 4));
      check("empty",        72'(empty),        72'(pre == 0));
      check("enq_ready",    72'(enq_ready),    72'(pre < 4));
      check("par_err",      72'(par_err),      72'(exp_pe != 4'h0));
      check("par_err_byte", 72'(par_err_byte), 72'(exp_pe));
      if (pre != 0)
        check("head", {2'b00, deq_data, deq_par, deq_be, deq_addr}, pack(exp_q[0]));
    end

    if (reset || flush) begin
      exp_q.delete();
      exp_pe = '0;
    end else begin
      if (pre != 0 && deq_ack) void'(exp_q.pop_front());
      exp_pe = '0;
      if (enq_valid && pre < 4) begin
        gp     = good_par(enq_data);
        exp_pe = enq_be & (enq_par ^ gp);
        if (pre >= 2 && enq_addr == exp_q[exp_q.size()-1].addr) begin
          t = exp_q.pop_back();
          for (int n = 0; n < 4; n++) begin
            if (enq_be[n]) begin
              t.data[8*n +: 8] = enq_data[8*n +: 8];
              t.par[n]         = enq_par[n];
            end
          end
          t.be = t.be | enq_be;
          exp_q.push_back(t);
        end else begin
          t.data = enq_data;
          t.par  = enq_par;
          t.be   = enq_be;
          t.addr = enq_addr;
          exp_q.push_back(t);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Presents one cycle of inputs; they are sampled by the next rising edge.
  task automatic drive(input logic r, input logic v, input logic [0:29] a,
                       input logic [0:31] d, input logic [0:3] b,
                       input logic [0:3] flip, input logic ack, input logic fl);
    reset     = r;
    enq_valid = v;
    enq_addr  = a;
    enq_data  = d;
    enq_be    = b;
    enq_par   = good_par(d) ^ flip;
    deq_ack   = ack;
    flush     = fl;
    @(posedge CB);
    #1;
  endtask

  task automatic enq(input logic [0:29] a, input logic [0:31] d, input logic [0:3] b);
    drive(1'b0, 1'b1, a, d, b, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic ack_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; enq_valid = 1'b0; enq_data = '0; enq_par = '0; enq_be = '0;
    enq_addr = '0; deq_ack = 1'b0; flush = 1'b0;
    @(posedge CB);
    #1;
    chk_en = 1'b1;
    drive(1'b1, 1'b0, '0, '0, '0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 30'h5, 32'hDEADBEEF, 4'hF, 4'h0, 1'b1, 1'b0);
    idle(1);

    // Single enqueue, visible the following cycle, then drained.
    enq(30'h10, 32'h11223344, 4'hF);
    idle(1);
    ack_n(1);

    // Fill to full, a fifth store is dropped, drain in order, extra ack ignored.
    for (int i = 0; i < 5; i++) enq(30'h20 + 30'(i), 32'hA0000000 + 32'(i * 32'h01010101), 4'hF);
    ack_n(5);

    // Merge into the tail: bytes 2-3 replaced, be accumulates, head untouched.
    enq(30'h30, 32'h01020304, 4'hF);
    enq(30'h31, 32'h05060708, 4'hC);
    enq(30'h31, 32'hAAAABBBB, 4'h3);
    idle(1);
    // Single entry: a matching address must not merge into the head.
    ack_n(1);
    enq(30'h31, 32'hCCCCCCCC, 4'hF);
    ack_n(3);

    // Parity error on byte 1, then same data with no bytes enabled.
    drive(1'b0, 1'b1, 30'h38, 32'h12345678, 4'hF, 4'h4, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 30'h39, 32'h12345678, 4'h0, 4'h4, 1'b0, 1'b0);
    idle(1);
    ack_n(2);

    // Flush with count=3 beats a concurrent enqueue (with bad parity) and ack.
    for (int i = 0; i < 3; i++) enq(30'h40 + 30'(i), 32'h0F0F0000 + 32'(i), 4'hF);
    drive(1'b0, 1'b1, 30'h43, 32'h55AA55AA, 4'hF, 4'h9, 1'b1, 1'b1);
    idle(2);

    // Full buffer: enqueue+ack rejects the enqueue; at count=2 both happen.
    for (int i = 0; i < 4; i++) enq(30'h50 + 30'(i), 32'h50500000 + 32'(i), 4'hF);
    drive(1'b0, 1'b1, 30'h54, 32'h54545454, 4'hF, 4'h0, 1'b1, 1'b0);
    ack_n(1);
    drive(1'b0, 1'b1, 30'h55, 32'h55555555, 4'hF, 4'h0, 1'b1, 1'b0);
    ack_n(3);

    // Reset in the middle of a drain discards everything.
    for (int i = 0; i < 3; i++) enq(30'h60 + 30'(i), 32'h60600000 + 32'(i), 4'hF);
    ack_n(1);
    drive(1'b1, 1'b1, 30'h63, 32'h63636363, 4'hF, 4'h2, 1'b1, 1'b0);
    idle(1);

    // Random traffic on a small address set so merges occur.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 2) != 0),
            30'h100 + 30'($urandom_range(0, 2)),
            32'($urandom),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 24) == 0));
    end
    ack_n(5);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
